// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI receive framer: FSM state encoding and default sizing.
package spi_rx_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT      = 2'd1,
        FLUSH_PEND = 2'd2,
        FLUSH_PART = 2'd3
    } state_e;

endpackage

// File: rtl/rx_word_fifo.sv
// Synchronous FIFO holding {last, word} entries; a push is accepted at full only alongside a pop.
module rx_word_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   push_ok
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_ok_s;

    // Occupancy flags, accept decisions and next pointer/count values
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        pop_ok_s = pop & ~empty;
        push_ok  = push & (~full | pop_ok_s);
        wr_ptr_d = push_ok  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // Empty FIFO presents zeros rather than stale storage
        pop_data = empty ? '0 : mem_q[rd_ptr_q];
        count    = count_q;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/spi_rx_framer.sv
// SPI receive framer: deserialises sdo into words, tags the final word of each cs frame, queues them.
module spi_rx_framer
    import spi_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MSB_FIRST  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cs,
    input  logic                   sck,
    input  logic                   sdo,
    input  logic                   capture_en,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   last_out,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic [7:0]             overflow_cnt,
    output logic                   frame_active
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d, pad_s;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted_s, part_s;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [7:0]            ovf_q, ovf_d;
    logic                  cs_q, cs_prev_q, sck_q, sck_prev_q, sdo_q;
    logic                  cs_fall_s, cs_rise_s, sample_s;
    logic                  push_s, push_last_s, push_ok_s;
    logic [DATA_WIDTH-1:0] push_word_s;
    logic [DATA_WIDTH:0]   head_s;

    // Edge detection, bit alignment and framing next-state logic
    always_comb begin
        cs_fall_s    = cs_prev_q & ~cs_q;
        cs_rise_s    = ~cs_prev_q & cs_q;
        sample_s     = sck_q & ~sck_prev_q & ~cs_q;
        pad_s        = CW'(DATA_WIDTH) - bit_cnt_q;
        if (MSB_FIRST != 0) begin
            shifted_s = {shift_q[DATA_WIDTH-2:0], sdo_q};
            part_s    = shift_q << pad_s;
        end else begin
            shifted_s = {sdo_q, shift_q[DATA_WIDTH-1:1]};
            part_s    = shift_q >> pad_s;
        end
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        push_s       = 1'b0;
        push_last_s  = 1'b0;
        push_word_s  = '0;
        case (state_q)
            IDLE: begin
                if (cs_fall_s && capture_en) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cs_rise_s) begin
                    if (pend_valid_q)           state_d = FLUSH_PEND;
                    else if (bit_cnt_q != '0)   state_d = FLUSH_PART;
                    else                        state_d = IDLE;
                end else if (sample_s) begin
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        // Completed word waits in pend so its last flag can be decided at cs rise
                        bit_cnt_d    = '0;
                        shift_d      = '0;
                        pend_d       = shifted_s;
                        pend_valid_d = 1'b1;
                        push_s       = pend_valid_q;
                        push_word_s  = pend_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        shift_d   = shifted_s;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            FLUSH_PEND: begin
                push_s       = 1'b1;
                push_word_s  = pend_q;
                push_last_s  = (bit_cnt_q == '0);
                pend_valid_d = 1'b0;
                state_d      = (bit_cnt_q != '0) ? FLUSH_PART : IDLE;
            end
            FLUSH_PART: begin
                push_s      = 1'b1;
                push_word_s = part_s;
                push_last_s = 1'b1;
                bit_cnt_d   = '0;
                shift_d     = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (push_s && !push_ok_s && ovf_q != 8'hFF) begin
            ovf_d = ovf_q + 8'd1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Input synchronisation stage and framing state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            ovf_q        <= 8'd0;
            cs_q         <= 1'b1;
            cs_prev_q    <= 1'b1;
            sck_q        <= 1'b0;
            sck_prev_q   <= 1'b0;
            sdo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            ovf_q        <= ovf_d;
            cs_q         <= cs;
            cs_prev_q    <= cs_q;
            sck_q        <= sck;
            sck_prev_q   <= sck_q;
            sdo_q        <= sdo;
        end
    end

    rx_word_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({push_last_s, push_word_s}),
        .pop       (ready_out),
        .pop_data  (head_s),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .push_ok   (push_ok_s)
    );

    assign valid_out    = ~empty;
    assign data_out     = head_s[DATA_WIDTH-1:0];
    assign last_out     = head_s[DATA_WIDTH];
    assign overflow_cnt = ovf_q;
    assign frame_active = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_rx_framer.sv
// Directed bench: two framers (MSB-first and LSB-first, DEPTH=4) driven by the same SPI stimulus.
module tb_spi_rx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b1, sck = 1'b0, sdo = 1'b0;
    logic       capture_en = 1'b1, ready = 1'b0;
    logic [7:0] data_a, data_b, ovf_a, ovf_b;
    logic       last_a, last_b, valid_a, valid_b, empty_a, empty_b;
    logic       full_a, full_b, act_a, act_b;
    logic [2:0] count_a, count_b;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    spi_rx_framer #(.DATA_WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) u_dut_a (
        .clk(clk), .rst(rst), .cs(cs), .sck(sck), .sdo(sdo), .capture_en(capture_en),
        .data_out(data_a), .last_out(last_a), .valid_out(valid_a), .ready_out(ready),
        .count(count_a), .empty(empty_a), .full(full_a), .overflow_cnt(ovf_a),
        .frame_active(act_a)
    );

    spi_rx_framer #(.DATA_WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) u_dut_b (
        .clk(clk), .rst(rst), .cs(cs), .sck(sck), .sdo(sdo), .capture_en(capture_en),
        .data_out(data_b), .last_out(last_b), .valid_out(valid_b), .ready_out(ready),
        .count(count_b), .empty(empty_b), .full(full_b), .overflow_cnt(ovf_b),
        .frame_active(act_b)
    );

    task automatic spi_bit(input logic b);
        @(negedge clk); sck = 1'b0; sdo = b;
        repeat (2) @(negedge clk);
        sck = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_low();
        @(negedge clk); sck = 1'b0; cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk); sck = 1'b0; cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({valid_a, empty_a, full_a, act_a, last_a, data_a} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_flags got v=%b e=%b f=%b act=%b l=%b d=%h exp v=0 e=1 f=0 act=0 l=0 d=00",
                     valid_a, empty_a, full_a, act_a, last_a, data_a);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({count_a, ovf_a, valid_a} !== {3'd0, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_count got count=%0d ovf=%0d v=%b exp 0 0 0", count_a, ovf_a, valid_a);
        end
    endtask

    task automatic test_full_frame();
        logic [7:0] exp_d [2] = '{8'hA5, 8'h3C};
        logic       exp_l [2] = '{1'b0, 1'b1};
        cs_low();
        vectors++;
        if (act_a !== 1'b1) begin
            miscompares++;
            $display("FAIL full_active got %b exp 1", act_a);
        end
        spi_byte(8'hA5);
        spi_byte(8'h3C);
        cs_high();
        vectors++;
        if ({count_a, ovf_a, act_a} !== {3'd2, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL full_count got count=%0d ovf=%0d act=%b exp 2 0 0", count_a, ovf_a, act_a);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({valid_a, last_a, data_a} !== {1'b1, exp_l[i], exp_d[i]}) begin
                miscompares++;
                $display("FAIL full_entry%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h",
                         i, valid_a, last_a, data_a, exp_l[i], exp_d[i]);
            end
            ready = 1'b1; @(negedge clk); ready = 1'b0;
        end
        vectors++;
        if ({valid_a, empty_a} !== 2'b01) begin
            miscompares++;
            $display("FAIL full_drained got v=%b e=%b exp v=0 e=1", valid_a, empty_a);
        end
    endtask

    task automatic test_partial_tail();
        logic [7:0] exp_a [2] = '{8'hFF, 8'hA0};
        logic [7:0] exp_b [2] = '{8'hFF, 8'h05};
        logic       exp_l [2] = '{1'b0, 1'b1};
        cs_low();
        spi_byte(8'hFF);
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
        cs_high();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({valid_a, last_a, data_a} !== {1'b1, exp_l[i], exp_a[i]}) begin
                miscompares++;
                $display("FAIL partial_msb%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h",
                         i, valid_a, last_a, data_a, exp_l[i], exp_a[i]);
            end
            vectors++;
            if ({valid_b, last_b, data_b} !== {1'b1, exp_l[i], exp_b[i]}) begin
                miscompares++;
                $display("FAIL partial_lsb%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h",
                         i, valid_b, last_b, data_b, exp_l[i], exp_b[i]);
            end
            ready = 1'b1; @(negedge clk); ready = 1'b0;
        end
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        cs_low();
        for (int i = 1; i <= 6; i++) spi_byte(8'(i));
        cs_high();
        vectors++;
        if ({count_a, full_a, ovf_a} !== {3'd4, 1'b1, 8'd2}) begin
            miscompares++;
            $display("FAIL ovf_state got count=%0d full=%b ovf=%0d exp 4 1 2", count_a, full_a, ovf_a);
        end
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if ({valid_a, last_a, data_a} !== {1'b1, 1'b0, 8'(i)}) begin
                miscompares++;
                $display("FAIL ovf_entry%0d got v=%b l=%b d=%h exp v=1 l=0 d=%h",
                         i, valid_a, last_a, data_a, 8'(i));
            end
            ready = 1'b1; @(negedge clk); ready = 1'b0;
        end
        vectors++;
        if ({empty_a, full_a, ovf_a} !== {1'b1, 1'b0, 8'd2}) begin
            miscompares++;
            $display("FAIL ovf_drained got e=%b f=%b ovf=%0d exp 1 0 2", empty_a, full_a, ovf_a);
        end
    endtask

    task automatic test_push_at_full();
        logic [7:0] exp_d [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
        logic       exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        ready = 1'b0;
        cs_low();
        spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33); spi_byte(8'h44); spi_byte(8'h55);
        @(negedge clk); sck = 1'b0; cs = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // The pending 0x55 is pushed in the coming cycle; pop alongside it
        vectors++;
        if ({full_a, count_a, data_a} !== {1'b1, 3'd4, 8'h11}) begin
            miscompares++;
            $display("FAIL pp_before got full=%b count=%0d d=%h exp 1 4 11", full_a, count_a, data_a);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({count_a, full_a, ovf_a} !== {3'd4, 1'b1, 8'd2}) begin
            miscompares++;
            $display("FAIL pp_after got count=%0d full=%b ovf=%0d exp 4 1 2", count_a, full_a, ovf_a);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({valid_a, last_a, data_a} !== {1'b1, exp_l[i], exp_d[i]}) begin
                miscompares++;
                $display("FAIL pp_entry%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h",
                         i, valid_a, last_a, data_a, exp_l[i], exp_d[i]);
            end
            ready = 1'b1; @(negedge clk); ready = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({valid_a, count_a, ovf_a} !== {1'b0, 3'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL rst_mid got v=%b count=%0d ovf=%0d exp 0 0 0", valid_a, count_a, ovf_a);
        end
        cs_high();
        cs_low();
        spi_byte(8'h81);
        cs_high();
        vectors++;
        if ({count_a, valid_a, last_a, data_a} !== {3'd1, 1'b1, 1'b1, 8'h81}) begin
            miscompares++;
            $display("FAIL rst_next got count=%0d v=%b l=%b d=%h exp 1 1 1 81",
                     count_a, valid_a, last_a, data_a);
        end
        ready = 1'b1; @(negedge clk); ready = 1'b0;
    endtask

    task automatic test_capture_en();
        capture_en = 1'b0;
        cs_low();
        vectors++;
        if (act_a !== 1'b0) begin
            miscompares++;
            $display("FAIL cap_off_active got %b exp 0", act_a);
        end
        spi_byte(8'h5A);
        cs_high();
        vectors++;
        if ({valid_a, count_a} !== {1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL cap_off got v=%b count=%0d exp 0 0", valid_a, count_a);
        end
        capture_en = 1'b1;
        cs_low();
        capture_en = 1'b0;
        spi_byte(8'hC3);
        cs_high();
        vectors++;
        if ({count_a, valid_a, last_a, data_a} !== {3'd1, 1'b1, 1'b1, 8'hC3}) begin
            miscompares++;
            $display("FAIL cap_drop got count=%0d v=%b l=%b d=%h exp 1 1 1 c3",
                     count_a, valid_a, last_a, data_a);
        end
        ready = 1'b1; @(negedge clk); ready = 1'b0;
        capture_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_partial_tail();
        test_overflow();
        test_push_at_full();
        test_mid_reset();
        test_capture_en();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_rx_framer.md
SPI_RX_FRAMER -- requirements
Module: spi_rx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per captured word, 4..32.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries, power of two, 4..1024.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in word MSB; 0 = in word LSB.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Ports:
  clk  in  1  system clock; all logic on rising edge.
  rst  in  1  synchronous active-high reset.
  cs  in  1  SPI chip select, active low; same clock domain as clk.
  sck  in  1  SPI clock; same clock domain as clk.
  sdo  in  1  SPI MISO data.
  capture_en  in  1  1 = frames are captured; 0 = frames are ignored.
  data_out  out  DATA_WIDTH  head-of-FIFO word.
  last_out  out  1  head word is the final word of its frame.
  valid_out  out  1  FIFO non-empty.
  ready_out  in  1  consumer accepts head word when valid_out=1.
  count  out  $clog2(DEPTH)+1  current FIFO occupancy.
  empty  out  1  count==0.
  full  out  1  count==DEPTH.
  overflow_cnt  out  8  words dropped because FIFO full; saturates at 255.
  frame_active  out  1  state is SHIFT.

Function
REQ-006 SHALL register cs, sck and sdo once (cs_q, sck_q, sdo_q); all edge detection uses registered values.
REQ-007 SHALL detect a bit sample when sck_q=1, previous sck_q=0 and cs_q=0, in state SHIFT.
REQ-008 SHALL implement states IDLE, SHIFT, FLUSH_PEND and FLUSH_PART.
REQ-009 In IDLE, on a cs_q falling edge with capture_en=1: go to SHIFT and clear bit_cnt. A falling edge with capture_en=0 is ignored for the whole frame.
REQ-010 In SHIFT, each sample SHALL shift sdo_q into the shift register in the order set by MSB_FIRST, and SHALL increment bit_cnt.
REQ-011 When the sample completing bit DATA_WIDTH-1 occurs:
  - the word moves into a one-entry pending register (pend_valid=1);
  - any previously pending word is pushed with last=0 in the same cycle;
  - bit_cnt returns to 0.
REQ-012 In SHIFT, on a cs_q rising edge:
  - if pend_valid=1, go to FLUSH_PEND;
  - else if bit_cnt>0, go to FLUSH_PART;
  - else go to IDLE.
REQ-013 FLUSH_PEND SHALL push the pending word with last = (bit_cnt==0) and clear pend_valid. It then goes to FLUSH_PART if bit_cnt>0, else to IDLE.
REQ-014 FLUSH_PART SHALL push the partial word with last=1 and go to IDLE.
  - MSB_FIRST=1: received bits are left-aligned and the unreceived LSBs are 0.
  - MSB_FIRST=0: received bits are right-aligned and the unreceived MSBs are 0.
REQ-015 A sample that coincides with a cs_q rising edge SHALL be discarded.
REQ-016 A frame of N complete words SHALL produce exactly N FIFO entries, with last=1 only on the Nth. A partial tail adds one more entry, which carries last=1 instead.
REQ-017 Dropping capture_en mid-frame SHALL NOT abort the frame; it affects only the next frame.
REQ-018 FIFO pop SHALL occur when valid_out & ready_out.
REQ-019 data_out and last_out SHALL be valid combinationally from the FIFO head whenever valid_out=1.
REQ-020 FIFO push SHALL be accepted when full=0, or when full=1 and a pop occurs in the same cycle.
REQ-021 A rejected push SHALL drop the word and increment overflow_cnt, saturating at 255. A dropped last-flagged word is not re-attached to any earlier entry.
REQ-022 A simultaneous push and pop SHALL leave count unchanged.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Latency: a word pushed in cycle t SHALL appear on valid_out in cycle t+1 if the FIFO was empty.

Reset
REQ-025 On rst=1 at a clk edge:
  - state = IDLE;
  - bit_cnt, shift register, pend_valid, FIFO pointers, count and overflow_cnt = 0;
  - cs_q = 1, sck_q = 0, sdo_q = 0.
REQ-026 Outputs during and after reset SHALL be:
  - valid_out = 0, empty = 1, full = 0, frame_active = 0;
  - data_out = 0, last_out = 0.
REQ-027 A reset mid-frame SHALL discard the partial and pending words. The next cs falling edge after rst deasserts SHALL start a new frame.

Structure
REQ-028 Shared package spi_rx_pkg SHALL hold the state enum and default parameter constants (DATA_WIDTH=8, DEPTH=16).
REQ-029 FIFO storage SHALL be one sub-module, rx_word_fifo, DATA_WIDTH+1 bits wide, DEPTH deep, with push/pop/count/empty/full.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
  - Full frame: DATA_WIDTH=8, MSB_FIRST=1, frame of bytes 0xA5, 0x3C -> entries {0xA5, last=0} then {0x3C, last=1}; overflow_cnt=0.
  - Partial tail: 8 bits 0xFF then 3 bits 101, then cs rises -> {0xFF, 0} then {0xA0, 1}. With MSB_FIRST=0, the same bits give {0xFF, 0} then {0x05, 1}.
  - Overflow: DEPTH=4, ready_out=0, 6-byte frame -> 4 entries held, full=1, overflow_cnt=2. Then ready_out=1 drains 4 entries.
  - Push at full with pop: DEPTH=4, FIFO full, push and pop in the same cycle -> push accepted, count stays 4, overflow_cnt unchanged.
  - Mid-frame reset: rst asserted after 5 bits -> valid_out=0, count=0. The next 1-byte frame 0x81 yields a single {0x81, last=1}.
  - capture_en: capture_en=0 at cs fall -> no entries for that frame. capture_en dropped mid-frame -> the frame completes normally.
